ysyx_25010008_trap_ctrl: RTL and testbench
==========================================

YSYX_25010008_TRAP_CTRL -- requirements
Module: ysyx_25010008_trap_ctrl

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flops synchronising io_interrupt (min 2).
REQ-002 clock  in  1  single core clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-004 io_interrupt  in  1  external interrupt level, asynchronous to clock.
REQ-005 timer_irq  in  1  machine timer interrupt level, synchronous to clock.
REQ-006 inst_done  in  1  one-cycle pulse: current instruction retires (write_back).
REQ-007 irq_inhibit  in  1  retiring instruction writes CSRs (ecall/mret/csrr*); blocks interrupt take that cycle.
REQ-008 next_pc  in  32  resume PC of retiring instruction (npc).
REQ-009 mtvec  in  32  current mtvec CSR value.
REQ-010 mstatus  in  32  current mstatus CSR value.
REQ-011 mie  in  32  current mie CSR value (bit 11 MEIE, bit 7 MTIE).
REQ-012 fetch_hold  out  1  forbids IFU from issuing the next fetch.
REQ-013 mepc_wen / mepc_wdata  out  1 / 32  mepc write strobe and data.
REQ-014 mcause_wen / mcause_wdata  out  1 / 32  mcause write strobe and data.
REQ-015 mstatus_wen / mstatus_wdata  out  1 / 32  mstatus write strobe and data.
REQ-016 redirect_valid / redirect_pc  out  1 / 32  PC redirect request to IFU.
REQ-017 redirect_ready  in  1  IFU accepts redirect.

Function
REQ-018 io_interrupt SHALL pass through SYNC_STAGES flops before use; timer_irq SHALL NOT be synchronised.
REQ-019 pending SHALL be (ext_sync & mie[11]) | (timer_irq & mie[7]); global enable SHALL be mstatus[3].
REQ-020 take SHALL be inst_done & ~irq_inhibit & mstatus[3] & pending & (state==IDLE).
REQ-021 Priority: external (code 11) over timer (code 7); cause latched at take, never re-evaluated.
REQ-022 States: IDLE, SAVE, STATUS, REDIRECT; IDLE->SAVE on take; SAVE->STATUS unconditionally; STATUS->REDIRECT unconditionally; REDIRECT->IDLE when redirect_valid & redirect_ready.
REQ-023 At take, next_pc and cause code SHALL be registered; mepc_wdata = latched next_pc, mcause_wdata = {1'b1, 27'b0, code[3:0]}.
REQ-024 SAVE: mepc_wen and mcause_wen SHALL be 1 for exactly that cycle; 0 otherwise.
REQ-025 STATUS: mstatus_wen = 1 for exactly that cycle; mstatus_wdata = mstatus input with bit7 (MPIE) := mstatus[3], bit3 (MIE) := 0, bits12:11 (MPP) := 2'b11, other bits unchanged.
REQ-026 REDIRECT: redirect_valid held 1 and redirect_pc stable until handshake; redirect_valid drops the cycle after acceptance.
REQ-027 redirect_pc: mtvec[1:0]==2'b01 -> {mtvec[31:2],2'b00} + (code<<2) (32-bit wrap); any other mode -> {mtvec[31:2],2'b00}.
REQ-028 fetch_hold SHALL be combinational take | (state != IDLE), so the fetch following the retiring instruction is suppressed in the take cycle.
REQ-029 Interrupts arriving while state != IDLE SHALL be ignored until return to IDLE; level sources re-evaluated at next inst_done.
REQ-030 inst_done with no enabled pending source, or with irq_inhibit=1: no state change, all outputs stay 0.
REQ-031 Interrupt deasserting after take SHALL NOT abort the sequence.
REQ-032 Latency: take cycle T -> mepc/mcause write T+1 -> mstatus write T+2 -> redirect_valid from T+3.

Reset
REQ-033 On reset=0 at a clock edge: state := IDLE, synchroniser flops := 0, latched cause/pc := 0; all outputs 0 next cycle.
REQ-034 Reset mid-sequence SHALL abandon it; no further CSR write or redirect is issued.

Verification
REQ-035 mstatus=0x8, mie=0x800, io_interrupt=1 for >=3 cycles, inst_done with next_pc=0x8000_0010, mtvec=0x8000_1000 -> mepc=0x8000_0010, mcause=0x8000_000B at T+1, mstatus_wdata=0x1880 at T+2, redirect_pc=0x8000_1000.
REQ-036 Both ext and timer pending, mie=0x880, mtvec=0x8000_1001 -> cause 0x8000_000B, redirect_pc=0x8000_102C.
REQ-037 Timer only, mie=0x080, mtvec=0x8000_1001 -> mcause=0x8000_0007, redirect_pc=0x8000_101C; redirect_ready held 0 for 4 cycles -> redirect_valid stays 1, pc stable, fetch_hold stays 1.
REQ-038 Pending with mstatus[3]=0, or irq_inhibit=1 at inst_done -> no strobes, fetch_hold=0.
REQ-039 reset=0 asserted in STATUS state -> mstatus_wen and redirect_valid never assert; state IDLE afterwards.

Source files
------------

// File: rtl/ysyx_25010008_trap_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_25010008_trap_ctrl
//
// Machine-mode interrupt entry sequencer. At an instruction boundary it
// decides whether to take a pending, enabled interrupt. If it does, it
// walks the CSR side effects in a fixed order:
//   SAVE     : write mepc and mcause
//   STATUS   : write mstatus (MPIE <- MIE, MIE <- 0, MPP <- M)
//   REDIRECT : ask the IFU to restart at the trap vector
// While a sequence is running, fetch_hold keeps the IFU quiet.
//
// Ports
//   clock, reset          core clock; synchronous active-low reset
//   io_interrupt          external interrupt level (asynchronous, synchronised here)
//   timer_irq             machine timer interrupt level (already in clock domain)
//   inst_done             one-cycle retire pulse
//   irq_inhibit           retiring instruction touches CSRs; no take this cycle
//   next_pc               resume PC of the retiring instruction
//   mtvec/mstatus/mie     current CSR values
//   fetch_hold            stop the IFU from issuing the next fetch
//   mepc_*/mcause_*/mstatus_*  CSR write strobes and data
//   redirect_valid/_pc/_ready  PC redirect handshake with the IFU
// ---------------------------------------------------------------------------
module ysyx_25010008_trap_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_interrupt,
  input  logic        timer_irq,
  input  logic        inst_done,
  input  logic        irq_inhibit,
  input  logic [31:0] next_pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mstatus,
  input  logic [31:0] mie,
  output logic        fetch_hold,
  output logic        mepc_wen,
  output logic [31:0] mepc_wdata,
  output logic        mcause_wen,
  output logic [31:0] mcause_wdata,
  output logic        mstatus_wen,
  output logic [31:0] mstatus_wdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAVE     = 2'd1,
    STATUS   = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [3:0]             code_reg;
  logic [31:0]            pc_reg;
  logic [31:0]            redirect_pc_reg;

  logic       ext_sync;
  logic       ext_pend;
  logic       tmr_pend;
  logic       take;
  logic [3:0] code_sel;
  logic [31:0] vec_base;

  // Only MEIE and MTIE matter here; fold the rest away explicitly.
  logic unused_mie_bits;
  assign unused_mie_bits = ^{mie[31:12], mie[10:8], mie[6:0]};

  // -------------------------------------------------------------------------
  // io_interrupt synchroniser (shift chain, oldest sample at the MSB)
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], io_interrupt};
    end
  end

  assign ext_sync = sync_reg[SYNC_STAGES-1];
  assign ext_pend = ext_sync & mie[11];
  assign tmr_pend = timer_irq & mie[7];
  assign take     = inst_done & ~irq_inhibit & mstatus[3] & (ext_pend | tmr_pend)
                  & (state_reg == IDLE);
  // External wins when both are pending.
  assign code_sel = ext_pend ? 4'd11 : 4'd7;
  assign vec_base = {mtvec[31:2], 2'b00};

  // -------------------------------------------------------------------------
  // State register and latched trap context
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg       <= IDLE;
      code_reg        <= '0;
      pc_reg          <= '0;
      redirect_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Cause and resume PC are frozen at take; sources dropping later
      // must not change what gets written.
      if (take) begin
        code_reg <= code_sel;
        pc_reg   <= next_pc;
      end
      // Target is captured once on the way into REDIRECT so it stays
      // stable for the whole handshake.
      if (state_reg == STATUS) begin
        if (mtvec[1:0] == 2'b01) begin
          redirect_pc_reg <= vec_base + {26'd0, code_reg, 2'b00};
        end else begin
          redirect_pc_reg <= vec_base;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (take) state_next = SAVE;
      SAVE:     state_next = STATUS;
      STATUS:   state_next = REDIRECT;
      REDIRECT: if (redirect_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs. Everything is qualified by reset being released so that a
  // reset landing mid-sequence suppresses the strobe of the current state
  // immediately rather than one cycle late.
  // -------------------------------------------------------------------------
  always_comb begin
    fetch_hold     = 1'b0;
    mepc_wen       = 1'b0;
    mepc_wdata     = '0;
    mcause_wen     = 1'b0;
    mcause_wdata   = '0;
    mstatus_wen    = 1'b0;
    mstatus_wdata  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (reset) begin
      fetch_hold = take | (state_reg != IDLE);
      case (state_reg)
        SAVE: begin
          mepc_wen     = 1'b1;
          mepc_wdata   = pc_reg;
          mcause_wen   = 1'b1;
          mcause_wdata = {1'b1, 27'd0, code_reg};
        end
        STATUS: begin
          mstatus_wen          = 1'b1;
          mstatus_wdata        = mstatus;
          mstatus_wdata[12:11] = 2'b11;
          mstatus_wdata[7]     = mstatus[3];
          mstatus_wdata[3]     = 1'b0;
        end
        REDIRECT: begin
          redirect_valid = 1'b1;
          redirect_pc    = redirect_pc_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25010008_trap_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_25010008_trap_ctrl.
// Stimulus pushes expected CSR writes / redirects (with the cycle they must
// appear in) and expected per-cycle signal levels into two queues; a monitor
// on the falling clock edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_ysyx_25010008_trap_ctrl;

  localparam int K_MEPC = 0, K_MCAUSE = 1, K_MSTATUS = 2, K_REDIR = 3;
  localparam int S_FH = 0, S_RV = 1, S_RPC = 2, S_ZERO = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_interrupt = 1'b0;
  logic        timer_irq = 1'b0;
  logic        inst_done = 1'b0;
  logic        irq_inhibit = 1'b0;
  logic [31:0] next_pc = '0;
  logic [31:0] mtvec = '0;
  logic [31:0] mstatus = '0;
  logic [31:0] mie = '0;
  logic        redirect_ready = 1'b1;
  logic        fetch_hold;
  logic        mepc_wen, mcause_wen, mstatus_wen, redirect_valid;
  logic [31:0] mepc_wdata, mcause_wdata, mstatus_wdata, redirect_pc;

  ysyx_25010008_trap_ctrl #(.SYNC_STAGES(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_interrupt   (io_interrupt),
    .timer_irq      (timer_irq),
    .inst_done      (inst_done),
    .irq_inhibit    (irq_inhibit),
    .next_pc        (next_pc),
    .mtvec          (mtvec),
    .mstatus        (mstatus),
    .mie            (mie),
    .fetch_hold     (fetch_hold),
    .mepc_wen       (mepc_wen),
    .mepc_wdata     (mepc_wdata),
    .mcause_wen     (mcause_wen),
    .mcause_wdata   (mcause_wdata),
    .mstatus_wen    (mstatus_wen),
    .mstatus_wdata  (mstatus_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  exp_t ev_q[$];
  exp_t lvl_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;
  bit   finished = 0;
  logic prev_valid = 1'b0;

  function automatic string kname(int k);
    case (k)
      K_MEPC:    return "mepc_write";
      K_MCAUSE:  return "mcause_write";
      K_MSTATUS: return "mstatus_write";
      default:   return "redirect";
    endcase
  endfunction

  function automatic string sname(int s);
    case (s)
      S_FH:    return "fetch_hold";
      S_RV:    return "redirect_valid";
      S_RPC:   return "redirect_pc_stable";
      default: return "outputs_idle";
    endcase
  endfunction

  // Called only from the monitor.
  task automatic check_ev(input int k, input logic [31:0] d);
    exp_t e;
    checks++;
    if (ev_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s cyc %0d: got data %h, none expected", kname(k), cyc, d);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != k || e.data != d || e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: got %s data %h at cyc %0d, want %s data %h at cyc %0d",
                 kname(e.kind), kname(k), d, cyc, kname(e.kind), e.data, e.cyc);
      end else begin
        $display("ok   %s data %h cyc %0d", kname(k), d, cyc);
      end
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clock) begin
    logic [31:0] act;
    exp_t        e;
    while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
      e = lvl_q.pop_front();
      case (e.kind)
        S_FH:    act = {31'd0, fetch_hold};
        S_RV:    act = {31'd0, redirect_valid};
        S_RPC:   act = redirect_pc;
        default: act = {31'd0, |{fetch_hold, mepc_wen, mcause_wen, mstatus_wen, redirect_valid,
                                  mepc_wdata, mcause_wdata, mstatus_wdata, redirect_pc}};
      endcase
      checks++;
      if (act != e.data || e.cyc != cyc) begin
        errors++;
        $display("FAIL %s cyc %0d: got %h, want %h (due cyc %0d)", sname(e.kind), cyc, act, e.data, e.cyc);
      end else begin
        $display("ok   %s cyc %0d = %h", sname(e.kind), cyc, act);
      end
    end
    if (mepc_wen)    check_ev(K_MEPC, mepc_wdata);
    if (mcause_wen)  check_ev(K_MCAUSE, mcause_wdata);
    if (mstatus_wen) check_ev(K_MSTATUS, mstatus_wdata);
    if (redirect_valid && !prev_valid) check_ev(K_REDIR, redirect_pc);
    prev_valid = redirect_valid;
    if (done && !finished) begin
      checks++;
      if (ev_q.size() != 0 || lvl_q.size() != 0) begin
        errors++;
        $display("FAIL leftover_expectations: got %0d events %0d levels pending, want 0 0",
                 ev_q.size(), lvl_q.size());
      end
      finished = 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_ev(input int k, input logic [31:0] d, input int c);
    exp_t e;
    e.kind = k; e.data = d; e.cyc = c;
    ev_q.push_back(e);
  endtask

  task automatic push_lvl(input int s, input logic [31:0] d, input int c);
    exp_t e;
    e.kind = s; e.data = d; e.cyc = c;
    lvl_q.push_back(e);
  endtask

  // Retire one instruction that must take an interrupt; queue its effects.
  task automatic take_irq(input logic [31:0] pc, input logic [31:0] tv, input logic [31:0] cause,
                          input logic [31:0] mst_exp, input logic [31:0] rpc, output int c);
    tick();
    next_pc = pc; mtvec = tv; inst_done = 1'b1;
    c = cyc;
    push_lvl(S_FH, 32'd1, c);
    push_ev(K_MEPC, pc, c + 1);
    push_ev(K_MCAUSE, cause, c + 1);
    push_ev(K_MSTATUS, mst_exp, c + 2);
    push_ev(K_REDIR, rpc, c + 3);
    tick();
    inst_done = 1'b0;
  endtask

  // Retire one instruction that must not take anything.
  task automatic no_take();
    tick();
    inst_done = 1'b1;
    push_lvl(S_FH, 32'd0, cyc);
    push_lvl(S_ZERO, 32'd0, cyc + 1);
    tick();
    inst_done = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (!fetch_hold) begin ok = 1; break; end
    end
    if (!ok) begin
      $display("FAIL wait_idle: fetch_hold still 1 after 30 cycles, want 0");
      $fatal(1, "sequence never returned to idle");
    end
    tick();
  endtask

  initial begin
    int c;
    // Reset state
    repeat (3) tick();
    push_lvl(S_ZERO, 32'd0, cyc);
    reset = 1'b1;
    tick();
    push_lvl(S_ZERO, 32'd0, cyc);

    // External interrupt, direct mode
    mstatus = 32'h8; mie = 32'h800; io_interrupt = 1'b1;
    repeat (3) tick();
    take_irq(32'h8000_0010, 32'h8000_1000, 32'h8000_000B, 32'h0000_1880, 32'h8000_1000, c);
    wait_idle();
    push_lvl(S_FH, 32'd0, cyc);

    // Both pending, vectored: external wins
    mie = 32'h880; timer_irq = 1'b1;
    take_irq(32'h8000_0020, 32'h8000_1001, 32'h8000_000B, 32'h0000_1880, 32'h8000_102C, c);
    wait_idle();

    // Timer only, vectored, redirect stalled 4 cycles; timer drops after take
    io_interrupt = 1'b0; mie = 32'h080; mstatus = 32'h0000_200A;
    repeat (3) tick();
    redirect_ready = 1'b0;
    take_irq(32'h8000_0104, 32'h8000_1001, 32'h8000_0007, 32'h0000_3882, 32'h8000_101C, c);
    timer_irq = 1'b0;
    for (int k = 3; k < 7; k++) begin
      push_lvl(S_FH, 32'd1, c + k);
      push_lvl(S_RV, 32'd1, c + k);
      push_lvl(S_RPC, 32'h8000_101C, c + k);
    end
    while (cyc < c + 7) tick();
    redirect_ready = 1'b1;
    tick();
    push_lvl(S_RV, 32'd0, cyc);
    wait_idle();

    // Pending but globally disabled, then pending but inhibited
    timer_irq = 1'b1; mie = 32'h080; mstatus = 32'h0;
    no_take();
    mstatus = 32'h8; irq_inhibit = 1'b1;
    no_take();
    irq_inhibit = 1'b0;

    // Reset lands in STATUS: no mstatus write and no redirect follow
    tick();
    next_pc = 32'h8000_0200; inst_done = 1'b1;
    c = cyc;
    push_ev(K_MEPC, 32'h8000_0200, c + 1);
    push_ev(K_MCAUSE, 32'h8000_0007, c + 1);
    tick();
    inst_done = 1'b0;
    tick();
    reset = 1'b0;
    push_lvl(S_ZERO, 32'd0, cyc);
    tick();
    push_lvl(S_ZERO, 32'd0, cyc);
    reset = 1'b1;
    timer_irq = 1'b0;
    repeat (6) tick();
    push_lvl(S_ZERO, 32'd0, cyc);
    repeat (2) tick();

    done = 1;
    for (int i = 0; i < 10 && !finished; i++) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
